// File: rtl/dbus_cbus_bridge_pkg.sv
// Shared typedefs for the uncached data-bus to cache-bus bridge.
// Holds the CPU and bus request/response structs and the bridge FSM states.
package dbus_cbus_bridge_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } mlen_t;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'd0,
      AXI_BURST_INCR  = 2'd1,
      AXI_BURST_WRAP  = 2'd2
   } axi_burst_t;

   typedef enum logic [1:0] {IDLE, BUS, DONE} bridge_state_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      msize_t            size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [DATA_W-1:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic              valid;
      logic              is_write;
      msize_t            size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
      mlen_t             len;
      axi_burst_t        burst;
   } cbus_req_t;

   typedef struct packed {
      logic              ready;
      logic              last;
      logic [DATA_W-1:0] data;
   } cbus_resp_t;

   // Request fields captured at acceptance and replayed on the bus.
   typedef struct packed {
      logic              is_write;
      msize_t            size;
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } bridge_lat_t;

endpackage

// File: rtl/dbus_cbus_bridge_if.sv
// Bundles the CPU-side and bus-side request/response structs of the bridge.
// master = CPU plus memory-side environment, slave = the bridge itself.
interface dbus_cbus_bridge_if;
   import dbus_cbus_bridge_pkg::*;

   dbus_req_t  dreq;
   dbus_resp_t dresp;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   modport master (output dreq, input dresp, input creq, output cresp);
   modport slave  (input dreq, output dresp, output creq, input cresp);
endinterface

// File: rtl/dbus_cbus_bridge.sv
// Uncached bridge: one dbus request becomes one single-beat cbus transaction.
// Latency: creq one cycle after accept, data_ok one cycle after ready&last; no new accept until back in IDLE.
module dbus_cbus_bridge
   import dbus_cbus_bridge_pkg::*;
#(
   parameter axi_burst_t BURST_TYPE = AXI_BURST_FIXED,
   parameter bit         HOLD_DATA  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   dbus_cbus_bridge_if.slave bus,
   output logic              busy
);

   bridge_state_t     state_q, state_d;
   bridge_lat_t       lat_q, lat_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              kill_q, kill_d;
   logic              done_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lat_q   <= '0;
         rdata_q <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
         kill_q  <= kill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      rdata_d = rdata_q;
      kill_d  = kill_q;
      case (state_q)
         IDLE: begin
            if (bus.dreq.valid) begin
               lat_d.is_write = |bus.dreq.strobe;
               lat_d.size     = bus.dreq.size;
               lat_d.addr     = bus.dreq.addr;
               lat_d.strobe   = bus.dreq.strobe;
               lat_d.data     = bus.dreq.data;
               kill_d         = 1'b0;
               state_d        = BUS;
            end
         end
         BUS: begin
            // The bus beat cannot be aborted; a withdrawn request only suppresses the reply.
            if (!bus.dreq.valid) begin
               kill_d = 1'b1;
            end
            if (bus.cresp.ready && bus.cresp.last) begin
               if (!lat_q.is_write) begin
                  rdata_d = bus.cresp.data;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            kill_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign done_ok = (state_q == DONE) && !kill_q;

   always_comb begin
      bus.creq          = '0;
      bus.creq.valid    = (state_q == BUS);
      bus.creq.is_write = lat_q.is_write;
      bus.creq.size     = lat_q.size;
      bus.creq.addr     = lat_q.addr;
      bus.creq.strobe   = lat_q.strobe;
      bus.creq.data     = lat_q.data;
      bus.creq.len      = MLEN1;
      bus.creq.burst    = BURST_TYPE;
   end

   always_comb begin
      bus.dresp         = '0;
      bus.dresp.addr_ok = done_ok;
      bus.dresp.data_ok = done_ok;
      bus.dresp.data    = (HOLD_DATA || done_ok) ? rdata_q : '0;
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dbus_cbus_bridge.sv
// Scoreboarded bench for dbus_cbus_bridge: expected bus requests and CPU replies
// are queued at launch and retired by a negedge monitor.
module tb_dbus_cbus_bridge;
   import dbus_cbus_bridge_pkg::*;

   localparam logic [63:0] GARB = 64'h0BAD_0BAD_0BAD_0BAD;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic busy;

   dbus_cbus_bridge_if bus();

   dbus_cbus_bridge dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int          n_vec   = 0;
   int          n_err   = 0;
   int          cyc_cnt = 0;
   cbus_req_t   exp_creq_q[$];
   logic [63:0] exp_resp_q[$];
   int          ok_times[$];
   logic [63:0] last_rd = '0;
   cbus_req_t   cur_creq = '0;
   logic        prev_cvld = 1'b0;
   logic        prev_ok   = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive a CPU request and queue what the bus and the CPU should see for it.
   task automatic launch(input logic [63:0] a, input msize_t sz, input logic [7:0] st,
                         input logic [63:0] wd, input logic [63:0] rd, input bit want_resp);
      cbus_req_t e;
      bus.dreq.valid  = 1'b1;
      bus.dreq.addr   = a;
      bus.dreq.size   = sz;
      bus.dreq.strobe = st;
      bus.dreq.data   = wd;
      e          = '0;
      e.valid    = 1'b1;
      e.is_write = (st != 8'h00);
      e.size     = sz;
      e.addr     = a;
      e.strobe   = st;
      e.data     = wd;
      e.len      = MLEN1;
      e.burst    = AXI_BURST_FIXED;
      exp_creq_q.push_back(e);
      if (st == 8'h00) last_rd = rd;
      if (want_resp) exp_resp_q.push_back(last_rd);
   endtask

   // Entered just after a clock edge with the bridge in BUS; returns just after the DONE edge.
   task automatic bus_reply(input int gap, input int nolast, input logic [63:0] d);
      for (int i = 0; i < gap; i++) begin
         check_val("creq_hold", 64'(bus.creq.valid), 64'd1);
         cyc();
      end
      for (int i = 0; i < nolast; i++) begin
         bus.cresp.ready = 1'b1;
         bus.cresp.last  = 1'b0;
         bus.cresp.data  = ~d;
         cyc();
         check_val("nolast_stays_bus", 64'({bus.creq.valid, bus.dresp.data_ok}), 64'(2'b10));
      end
      bus.cresp.ready = 1'b1;
      bus.cresp.last  = 1'b1;
      bus.cresp.data  = d;
      cyc();
      bus.cresp.ready = 1'b0;
      bus.cresp.last  = 1'b0;
      bus.cresp.data  = GARB;
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.creq.valid) begin
            if (!prev_cvld) begin
               check_val("creq_expected", 64'(exp_creq_q.size() != 0), 64'd1);
               if (exp_creq_q.size() != 0) begin
                  cur_creq = exp_creq_q.pop_front();
                  check_val("creq_addr", bus.creq.addr, cur_creq.addr);
                  check_val("creq_data", bus.creq.data, cur_creq.data);
                  check_val("creq_ctl",
                     64'({bus.creq.is_write, bus.creq.size, bus.creq.strobe, bus.creq.len, bus.creq.burst}),
                     64'({cur_creq.is_write, cur_creq.size, cur_creq.strobe, cur_creq.len, cur_creq.burst}));
               end
            end else begin
               check_val("creq_stable", 64'(bus.creq == cur_creq), 64'd1);
            end
         end
         check_val("ok_equal", 64'(bus.dresp.addr_ok), 64'(bus.dresp.data_ok));
         if (bus.dresp.data_ok) begin
            check_val("ok_one_cycle", 64'(prev_ok), 64'd0);
            check_val("resp_expected", 64'(exp_resp_q.size() != 0), 64'd1);
            if (exp_resp_q.size() != 0) check_val("resp_data", bus.dresp.data, exp_resp_q.pop_front());
            ok_times.push_back(cyc_cnt);
         end
      end
      prev_cvld = (rst_n === 1'b1) && bus.creq.valid;
      prev_ok   = (rst_n === 1'b1) && bus.dresp.data_ok;
   end

   initial begin
      bus.dreq       = '0;
      bus.cresp      = '0;
      bus.cresp.data = GARB;
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_creq_valid", 64'(bus.creq.valid), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_data_ok", 64'({bus.dresp.addr_ok, bus.dresp.data_ok}), 64'd0);
      check_val("rst_dresp_data", bus.dresp.data, 64'd0);
      check_val("rst_creq_addr", bus.creq.addr, 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      cyc();

      // Read with a two-cycle bus answer.
      launch(64'h1000_0000, MSIZE4, 8'h00, 64'h0, 64'hDEAD_BEEF_0000_1234, 1'b1);
      check_val("rd_not_comb", 64'(bus.creq.valid), 64'd0);
      cyc();
      check_val("rd_creq_next", 64'(bus.creq.valid), 64'd1);
      check_val("rd_busy", 64'(busy), 64'd1);
      bus_reply(2, 0, 64'hDEAD_BEEF_0000_1234);
      check_val("rd_data_ok", 64'(bus.dresp.data_ok), 64'd1);
      check_val("rd_data", bus.dresp.data, 64'hDEAD_BEEF_0000_1234);
      check_val("rd_creq_drop", 64'(bus.creq.valid), 64'd0);
      bus.dreq.valid = 1'b0;
      cyc();
      check_val("rd_ok_pulse", 64'(bus.dresp.data_ok), 64'd0);
      check_val("rd_busy_fall", 64'(busy), 64'd0);
      check_val("rd_data_hold", bus.dresp.data, 64'hDEAD_BEEF_0000_1234);

      // Write: response data keeps the previous read value.
      cyc();
      launch(64'h1000_0008, MSIZE4, 8'h0F, 64'h0000_0000_CAFE_F00D, 64'h0, 1'b1);
      cyc();
      bus_reply(1, 0, 64'h5555_5555_5555_5555);
      check_val("wr_data_ok", 64'(bus.dresp.data_ok), 64'd1);
      check_val("wr_data_kept", bus.dresp.data, 64'hDEAD_BEEF_0000_1234);
      bus.dreq.valid = 1'b0;
      cyc();

      // Flush: request withdrawn in the second BUS cycle.
      launch(64'h1000_0010, MSIZE8, 8'h00, 64'h0, 64'h7777_0000_7777_0000, 1'b0);
      cyc();
      cyc();
      bus.dreq.valid = 1'b0;
      bus_reply(1, 0, 64'h7777_0000_7777_0000);
      check_val("fl_no_ok", 64'(bus.dresp.data_ok), 64'd0);
      check_val("fl_busy_done", 64'(busy), 64'd1);
      cyc();
      check_val("fl_idle", 64'(busy), 64'd0);
      check_val("fl_rdata", bus.dresp.data, last_rd);

      // Ready without last is not a completion.
      launch(64'h1000_0040, MSIZE4, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1);
      cyc();
      bus_reply(0, 3, 64'h0123_4567_89AB_CDEF);
      check_val("nl_data_ok", 64'(bus.dresp.data_ok), 64'd1);
      bus.dreq.valid = 1'b0;
      cyc();
      check_val("nl_ok_pulse", 64'(bus.dresp.data_ok), 64'd0);

      // Asynchronous reset in the middle of BUS.
      launch(64'h3000, MSIZE4, 8'h00, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
      cyc();
      check_val("rst_pre_bus", 64'(bus.creq.valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_creq_valid", 64'(bus.creq.valid), 64'd0);
      check_val("arst_busy", 64'(busy), 64'd0);
      check_val("arst_data_ok", 64'(bus.dresp.data_ok), 64'd0);
      check_val("arst_dresp_data", bus.dresp.data, 64'd0);
      bus.dreq = '0;
      exp_creq_q.delete();
      exp_resp_q.delete();
      last_rd = '0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      cyc();
      launch(64'h2000, MSIZE8, 8'h00, 64'h0, 64'h2000_2000_2000_2000, 1'b1);
      cyc();
      check_val("post_rst_creq", 64'(bus.creq.valid), 64'd1);
      bus_reply(1, 0, 64'h2000_2000_2000_2000);
      check_val("post_rst_ok", 64'(bus.dresp.data_ok), 64'd1);
      check_val("post_rst_data", bus.dresp.data, 64'h2000_2000_2000_2000);
      bus.dreq.valid = 1'b0;
      cyc();

      // Back-to-back reads with valid held across the first data_ok.
      launch(64'h10, MSIZE8, 8'h00, 64'h0, 64'h1111_2222_3333_4444, 1'b1);
      cyc();
      bus_reply(0, 0, 64'h1111_2222_3333_4444);
      check_val("b2b_ok1", 64'(bus.dresp.data_ok), 64'd1);
      launch(64'h18, MSIZE8, 8'h00, 64'h0, 64'h5555_6666_7777_8888, 1'b1);
      cyc();
      check_val("b2b_idle", 64'({busy, bus.creq.valid, bus.dresp.data_ok}), 64'd0);
      cyc();
      check_val("b2b_creq2", 64'(bus.creq.valid), 64'd1);
      bus_reply(0, 0, 64'h5555_6666_7777_8888);
      check_val("b2b_ok2", 64'(bus.dresp.data_ok), 64'd1);
      bus.dreq.valid = 1'b0;
      repeat (5) cyc();
      check_val("b2b_no_third", 64'({busy, bus.creq.valid}), 64'd0);
      check_val("b2b_two_pulses", 64'(ok_times.size() >= 2), 64'd1);
      if (ok_times.size() >= 2)
         check_val("b2b_gap", 64'((ok_times[ok_times.size()-1] - ok_times[ok_times.size()-2]) >= 3), 64'd1);

      check_val("creq_q_empty", 64'(exp_creq_q.size()), 64'd0);
      check_val("resp_q_empty", 64'(exp_resp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dbus_cbus_bridge.md
Name: dbus_cbus_bridge

Overview:
- Uncached data-path bridge. Consumes CPU-side data-bus requests (dbus_req_t) and issues single-beat cache-bus transactions (cbus_req_t) toward the memory/AXI adapter.
- Returns the result on dbus_resp_t.
- Sits directly downstream of the pipeline memory stage for MMIO/uncached regions, in parallel with the data cache.

Parameters:
- BURST_TYPE, AXI_BURST_FIXED, burst field driven on every creq.
- HOLD_DATA, 1, when 1 dresp.data keeps the last read value while idle; when 0 it is driven to 0 while idle.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- dreq  input  dbus_req_t  CPU request; held stable until data_ok or withdrawn.
- dresp  output  dbus_resp_t  addr_ok/data_ok/data to CPU.
- creq  output  cbus_req_t  cache-bus request.
- cresp  input  cbus_resp_t  ready/last/data from bus.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - creq.valid=0, all latched fields 0.
  - dresp.addr_ok=data_ok=0, dresp.data=0, busy=0.
  - Reset mid-transaction abandons it; no response is produced.
- States: IDLE, BUS, DONE.
- IDLE:
  - If dreq.valid=1, latch addr, size, strobe and data. Latch is_write = |dreq.strobe. Go to BUS.
  - No dresp asserted in IDLE.
- BUS: creq.valid=1 every cycle, with:
  - is_write, size, addr, strobe, data taken from the latch;
  - len=MLEN1, burst=BURST_TYPE.
  - Fields must not change while in BUS.
- BUS completion:
  - On cresp.ready=1 && cresp.last=1: latch cresp.data (reads only; writes keep the previous rdata) and go to DONE.
  - creq.valid drops in the following cycle.
  - cresp.ready=1 with last=0 is ignored; stay in BUS.
- Withdrawal (flush): dreq.valid=0 in any cycle of BUS sets the kill flag. The bus transaction still completes, because AXI cannot abort.
- DONE:
  - If kill=0: dresp.addr_ok=1 and dresp.data_ok=1 for exactly one cycle, dresp.data = latched rdata.
  - If kill=1: no pulse, and kill is cleared.
  - Always return to IDLE next cycle.
  - A new dreq is not accepted in DONE; earliest acceptance is the IDLE cycle that follows.
- Latency:
  - dreq.valid sampled in IDLE at cycle N gives creq.valid from N+1.
  - ready&last at cycle M gives data_ok at M+1.
  - Minimum round trip is 3 cycles.
- Back-to-back: the CPU keeping dreq.valid=1 after data_ok with a new address is accepted in IDLE (cycle after DONE).
- Widths:
  - Data and address pass through unmodified at 64 bits.
  - The strobe/data lane placement is the requester's responsibility; the bridge performs no shifting.
- dresp.addr_ok and dresp.data_ok are always equal.

Decomposition:
- bridge_state_t (enum logic[1:0]: IDLE, BUS, DONE) goes in the shared common package next to the bus typedefs.
- Single module, no sub-modules; the FSM and request/response latches are all local.

Test Plan:
- Read: dreq{valid=1, addr=64'h1000_0000, size=MSIZE4, strobe=0} → creq.valid=1 next cycle with is_write=0, len=MLEN1, addr=64'h1000_0000. Bus answers ready=1, last=1, data=64'hDEAD_BEEF_0000_1234 after 2 cycles → one-cycle data_ok with that data; busy falls one cycle later.
- Write: strobe=8'h0F, data=64'h0000_0000_CAFE_F00D, size=MSIZE4 → creq.is_write=1 with strobe and data unchanged. ready&last → one data_ok pulse; dresp.data retains the prior read value (HOLD_DATA=1).
- Flush: dreq.valid dropped in the 2nd BUS cycle → creq.valid stays 1 until ready&last; no data_ok pulse; FSM back in IDLE two cycles after completion.
- ready without last: cresp.ready=1, last=0 for 3 cycles, then ready=1, last=1 → state stays BUS throughout; data_ok appears exactly one cycle after the last beat.
- Async reset: rst_n pulled low mid-BUS (asynchronous to clk) → creq.valid=0 and busy=0 before the next clock edge. After release, a new read to 64'h2000 completes normally.
- Back-to-back: two reads (64'h10, 64'h18) with dreq.valid held continuously → two distinct creq transactions and two data_ok pulses separated by ≥3 cycles; no spurious third request.
